// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared FSM state type and kernel/dimension constants for the conv sequencer
package conv_seq_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int KERNEL_DIM = 3;
  localparam int KERNEL_TAPS = 9;
  localparam int N_MIN = 3;
  localparam int N_MAX = 63;
  typedef enum logic [2:0] {IDLE, HDR_REQ, HDR_WAIT, COMPUTE, DRAIN} state_t;
endpackage

// File: rtl/conv_seq_addr_gen.sv
// conv_addr_gen: 3x3 window address walker (in: hdr/start/step, n; out: rd_addr, w_addr, first, last) using adders only
module conv_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int AW = conv_seq_pkg::ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hdr,
  input  logic          start,
  input  logic          step,
  input  logic [AW-1:0] n,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] w_addr,
  output logic          first,
  output logic          last
);
  localparam logic [1:0] JMAX = 2'(KERNEL_DIM - 1);
  logic [AW-1:0] n_q, n_d, c_q, c_d, r_q, r_d, rb_q, rb_d, pb_q, pb_d, rs_q, rs_d, rd_q, rd_d;
  logic [1:0] j_q, j_d, i_q, i_d;
  logic [3:0] w_q, w_d;
  logic [AW-1:0] lim, nxt_row;
  assign lim = n_q - AW'(KERNEL_DIM);
  assign nxt_row = rs_q + n_q;
  assign rd_addr = rd_q;
  assign w_addr = AW'(w_q);
  assign first = w_q == 4'd0;
  assign last = w_q == 4'(KERNEL_TAPS - 1) && c_q == lim && r_q == lim;
  always_comb begin
    n_d = n_q;
    j_d = j_q;
    i_d = i_q;
    c_d = c_q;
    r_d = r_q;
    rb_d = rb_q;
    pb_d = pb_q;
    rs_d = rs_q;
    rd_d = rd_q;
    w_d = w_q;
    if (hdr) rd_d = '0;
    else if (start) begin
      n_d = n;
      j_d = '0;
      i_d = '0;
      c_d = '0;
      r_d = '0;
      w_d = '0;
      rb_d = AW'(1);
      pb_d = AW'(1);
      rs_d = AW'(1);
      rd_d = AW'(1);
    end else if (step) begin
      if (j_q != JMAX) begin
        j_d = j_q + 2'd1;
        w_d = w_q + 4'd1;
        rd_d = rd_q + AW'(1);
      end else if (i_q != JMAX) begin
        j_d = '0;
        i_d = i_q + 2'd1;
        w_d = w_q + 4'd1;
        rb_d = rb_q + n_q;
        rd_d = rb_q + n_q;
      end else if (c_q != lim) begin
        j_d = '0;
        i_d = '0;
        w_d = '0;
        c_d = c_q + AW'(1);
        pb_d = pb_q + AW'(1);
        rb_d = pb_q + AW'(1);
        rd_d = pb_q + AW'(1);
      end else begin
        j_d = '0;
        i_d = '0;
        w_d = '0;
        c_d = '0;
        r_d = r_q + AW'(1);
        rs_d = nxt_row;
        pb_d = nxt_row;
        rb_d = nxt_row;
        rd_d = nxt_row;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q <= '0;
      j_q <= '0;
      i_q <= '0;
      c_q <= '0;
      r_q <= '0;
      rb_q <= '0;
      pb_q <= '0;
      rs_q <= '0;
      rd_q <= '0;
      w_q <= '0;
    end else begin
      n_q <= n_d;
      j_q <= j_d;
      i_q <= i_d;
      c_q <= c_d;
      r_q <= r_d;
      rb_q <= rb_d;
      pb_q <= pb_d;
      rs_q <= rs_d;
      rd_q <= rd_d;
      w_q <= w_d;
    end
  end
endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: 3x3 conv run sequencer (in: dut_run, sram_dut_read_data; out: busy, SRAM/weight addresses, mac_en/mac_clr, write strobe/address, cfg_err)
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = conv_seq_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dut_run,
  output logic                  dut_busy,
  output logic [ADDR_WIDTH-1:0] dut_sram_read_address,
  input  logic [DATA_WIDTH-1:0] sram_dut_read_data,
  output logic [ADDR_WIDTH-1:0] dut_wmem_read_address,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic                  dut_sram_write_enable,
  output logic [ADDR_WIDTH-1:0] dut_sram_write_address,
  output logic                  cfg_err
);
  state_t state_q, state_d;
  logic cfg_err_q, cfg_err_d, mac_en_q, mac_en_d, mac_clr_q, mac_clr_d;
  logic [KERNEL_TAPS:0] fp_q, fp_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic hdr, start, step, first, last, compute, legal;
  assign compute = state_q == COMPUTE;
  assign step = compute && !last;
  assign legal = sram_dut_read_data >= DATA_WIDTH'(N_MIN) && sram_dut_read_data <= DATA_WIDTH'(N_MAX);
  assign dut_busy = state_q != IDLE;
  assign cfg_err = cfg_err_q;
  assign mac_en = mac_en_q;
  assign mac_clr = mac_clr_q;
  assign dut_sram_write_enable = fp_q[KERNEL_TAPS];
  assign dut_sram_write_address = wa_q;
  conv_addr_gen #(.AW(ADDR_WIDTH)) u_addr (
    .clk(clk),
    .rst(reset),
    .hdr(hdr),
    .start(start),
    .step(step),
    .n(sram_dut_read_data[ADDR_WIDTH-1:0]),
    .rd_addr(dut_sram_read_address),
    .w_addr(dut_wmem_read_address),
    .first(first),
    .last(last)
  );
  always_comb begin
    state_d = state_q;
    cfg_err_d = cfg_err_q;
    hdr = 1'b0;
    start = 1'b0;
    case (state_q)
      IDLE: if (dut_run) begin
        state_d = HDR_REQ;
        cfg_err_d = 1'b0;
        hdr = 1'b1;
      end
      HDR_REQ: state_d = HDR_WAIT;
      HDR_WAIT: begin
        state_d = legal ? COMPUTE : IDLE;
        cfg_err_d = !legal;
        start = legal;
      end
      COMPUTE: state_d = last ? DRAIN : COMPUTE;
      DRAIN: state_d = fp_q[KERNEL_TAPS] ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    mac_en_d = compute;
    mac_clr_d = compute && first;
    // the first-tap marker reaches the end of the 10-deep pipe the cycle after that pixel's last mac_en
    fp_d = {fp_q[KERNEL_TAPS-1:0], compute && first};
    wa_d = hdr ? '0 : wa_q + ADDR_WIDTH'(fp_q[KERNEL_TAPS]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_err_q <= 1'b0;
      mac_en_q <= 1'b0;
      mac_clr_q <= 1'b0;
      fp_q <= '0;
      wa_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_err_q <= cfg_err_d;
      mac_en_q <= mac_en_d;
      mac_clr_q <= mac_clr_d;
      fp_q <= fp_d;
      wa_q <= wa_d;
    end
  end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: table-driven and randomized checks of conv_sequencer against a formula-based cycle model
module tb_conv_sequencer;
  logic clk = 0, reset = 1, dut_run = 0;
  logic [15:0] sram_dut_read_data = '0;
  logic dut_busy, mac_clr, mac_en, dut_sram_write_enable, cfg_err;
  logic [11:0] dut_sram_read_address, dut_wmem_read_address, dut_sram_write_address;
  int checks = 0, passed = 0;
  int exp_rd = 0, exp_w = 0;
  bit exp_cfg = 0;
  typedef struct {
    int n;
    bit hold;
    int rst_at;
    int wr;
    int busy;
    int lwa;
    int lrd;
  } vec_t;
  vec_t tbl[10];
  always #5 clk = ~clk;
  conv_sequencer dut (
    .clk(clk),
    .reset(reset),
    .dut_run(dut_run),
    .dut_busy(dut_busy),
    .dut_sram_read_address(dut_sram_read_address),
    .sram_dut_read_data(sram_dut_read_data),
    .dut_wmem_read_address(dut_wmem_read_address),
    .mac_clr(mac_clr),
    .mac_en(mac_en),
    .dut_sram_write_enable(dut_sram_write_enable),
    .dut_sram_write_address(dut_sram_write_address),
    .cfg_err(cfg_err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask
  task automatic cmp_cycle(input string name, input bit eb, ee, ec, ew, input int wa);
    chk(name,
        {23'd0, dut_busy, mac_en, mac_clr, dut_sram_write_enable, cfg_err, dut_sram_read_address,
         dut_wmem_read_address, ew ? dut_sram_write_address : 12'd0},
        {23'd0, eb, ee, ec, ew, exp_cfg, 12'(exp_rd), 12'(exp_w), ew ? 12'(wa) : 12'd0});
  endtask
  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      cmp_cycle("idle", 0, 0, 0, 0, 0);
    end
  endtask
  task automatic run(input int n, input bit hold, input int rst_at, output bit chain,
                     output int nwr, output int nbusy, output int last_wa, output int last_rd);
    bit legal, rs, eb, ee, ec, ew;
    int p, kend, t, pp, tp, r, c, wa;
    legal = n >= 3 && n <= 63;
    p = legal ? (n - 2) * (n - 2) : 0;
    kend = legal ? 5 + 9 * p : 3;
    rs = 0;
    nwr = 0;
    nbusy = 0;
    last_wa = 0;
    last_rd = 0;
    dut_run = 1;
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      wa = 0;
      if (rs) begin
        eb = 0; ee = 0; ec = 0; ew = 0;
        exp_rd = 0; exp_w = 0; exp_cfg = 0;
      end else begin
        eb = legal ? k <= 4 + 9 * p : k <= 2;
        if (k == 1) begin
          exp_rd = 0;
          exp_cfg = 0;
        end
        if (!legal && k == 3) exp_cfg = 1;
        if (legal && k >= 3 && k < 3 + 9 * p) begin
          t = k - 3; pp = t / 9; tp = t % 9;
          r = pp / (n - 2); c = pp % (n - 2);
          exp_rd = 1 + (r + tp / 3) * n + c + tp % 3;
          exp_w = tp;
        end
        ee = legal && k >= 4 && k <= 3 + 9 * p;
        ec = ee && (k - 4) % 9 == 0;
        ew = legal && k >= 13 && (k - 13) % 9 == 0 && (k - 13) / 9 < p;
        wa = ew ? (k - 13) / 9 : 0;
      end
      cmp_cycle(rs ? "post_reset" : "cycle", eb, ee, ec, ew, wa);
      nbusy += int'(dut_busy);
      nwr += int'(dut_sram_write_enable);
      if (dut_sram_write_enable) last_wa = int'(dut_sram_write_address);
      last_rd = int'(dut_sram_read_address);
      if (rs) begin
        reset = 0;
        break;
      end
      if (k == 1) dut_run = hold;
      sram_dut_read_data = (dut_sram_read_address == 0) ? 16'(n) : 16'($urandom);
      if (k == rst_at && k < kend) begin
        reset = 1;
        dut_run = 0;
        rs = 1;
      end
    end
    chain = hold && !rs;
  endtask
  initial begin
    bit chain;
    int nwr, nbusy, lwa, lrd, n, ra;
    tbl[0] = '{3, 0, 0, 1, 13, 0, 9};
    tbl[1] = '{4, 0, 0, 4, 40, 3, 16};
    tbl[2] = '{2, 0, 0, 0, 2, 0, 0};
    tbl[3] = '{65535, 0, 0, 0, 2, 0, 0};
    tbl[4] = '{3, 0, 0, 1, 13, 0, 9};
    tbl[5] = '{10, 0, 20, 1, 20, 0, 0};
    tbl[6] = '{10, 0, 0, 64, 580, 63, 100};
    tbl[7] = '{3, 1, 0, 1, 13, 0, 9};
    tbl[8] = '{3, 0, 0, 1, 13, 0, 9};
    tbl[9] = '{63, 0, 0, 3721, 33493, 3720, 3969};
    repeat (3) @(negedge clk);
    cmp_cycle("reset_state", 0, 0, 0, 0, 0);
    reset = 0;
    idle(2);
    chain = 0;
    foreach (tbl[v]) begin
      if (!chain) idle(2);
      run(tbl[v].n, tbl[v].hold, tbl[v].rst_at, chain, nwr, nbusy, lwa, lrd);
      chk($sformatf("writes_n%0d", tbl[v].n), 64'(nwr), 64'(tbl[v].wr));
      chk($sformatf("busy_cycles_n%0d", tbl[v].n), 64'(nbusy), 64'(tbl[v].busy));
      chk($sformatf("last_waddr_n%0d", tbl[v].n), 64'(lwa), 64'(tbl[v].lwa));
      chk($sformatf("last_raddr_n%0d", tbl[v].n), 64'(lrd), 64'(tbl[v].lrd));
    end
    for (int i = 0; i < 8; i++) begin
      if (!chain) idle(1 + int'($urandom_range(0, 2)));
      n = int'($urandom_range(0, 17));
      if (n == 17) n = 64;
      ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
      run(n, 1'($urandom_range(0, 1)), ra, chain, nwr, nbusy, lwa, lrd);
    end
    dut_run = 0;
    if (chain) begin
      run(3, 0, 0, chain, nwr, nbusy, lwa, lrd);
      chk("writes_final", 64'(nwr), 64'd1);
    end
    idle(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, 12, width of all SRAM address ports.
REQ-002 Parameter DATA_WIDTH, 16, width of SRAM read data.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port dut_run  in  1  start request, level-sampled.
REQ-006 Port dut_busy  out  1  high from run acceptance until the final write completes.
REQ-007 Port dut_sram_read_address  out  ADDR_WIDTH  input SRAM read address.
REQ-008 Port sram_dut_read_data  in  DATA_WIDTH  input SRAM data, valid one cycle after its address.
REQ-009 Port dut_wmem_read_address  out  ADDR_WIDTH  weight SRAM read address.
REQ-010 Port mac_clr  out  1  external MAC loads the product instead of accumulating it; asserted on the first-tap data cycle of each pixel.
REQ-011 Port mac_en  out  1  external MAC consumes read data this cycle.
REQ-012 Port dut_sram_write_enable  out  1  output SRAM write strobe.
REQ-013 Port dut_sram_write_address  out  ADDR_WIDTH  output SRAM write address (pixel index).
REQ-014 Port cfg_err  out  1  last run rejected an illegal dimension.

Function
REQ-015 Cycle numbering: cycle 0 is the IDLE cycle in which dut_run is sampled high.
REQ-016 States: IDLE, HDR_REQ, HDR_WAIT, COMPUTE, DRAIN.
REQ-017 Transition IDLE->HDR_REQ occurs on dut_run=1; dut_busy=1 from cycle 1; dut_run is ignored outside IDLE.
REQ-018 HDR_REQ (cycle 1) drives input address 0.
REQ-019 HDR_WAIT (cycle 2) latches N = sram_dut_read_data.
REQ-020 Legal N is 3..63; an illegal N returns to IDLE at cycle 3 with dut_busy=0 and cfg_err=1, and no writes occur.
REQ-021 The cfg_err flag is cleared when the next run is accepted.
REQ-022 Output count P = (N-2)^2; pixel p=(r,c) is raster order, r,c in 0..N-3.
REQ-023 COMPUTE issues 9 taps per pixel back-to-back, with no bubbles between pixels, starting at cycle 3.
REQ-024 Taps follow order (i,j), i outer, each 0..2.
REQ-025 Input address per tap = 1 + (r+i)*N + (c+j).
REQ-026 Weight address per tap = 3*i + j.
REQ-027 The mac_en signal is asserted exactly one cycle after each tap address (cycles 4..3+9P).
REQ-028 The mac_clr signal coincides with mac_en of tap (0,0).
REQ-029 Pixel p is written at cycle 13+9p: dut_sram_write_enable=1 for one cycle, address = p.
REQ-030 DRAIN covers the cycles after the last address until the last write; dut_busy falls at cycle 5+9P, i.e. busy high for 4+9P cycles.
REQ-031 At least one IDLE cycle with dut_busy=0 separates runs; if dut_run is still high in that cycle, the next run starts.
REQ-032 Addresses outside tap cycles hold their last value; write address is don't-care when the write strobe is low.
REQ-033 Address arithmetic is unsigned ADDR_WIDTH and requires no wrap for legal N (max input address 3969, max output address 3720).

Reset
REQ-034 Reset=1 at a clock edge forces IDLE, regardless of state, including mid-COMPUTE.
REQ-035 Reset=1 at a clock edge zeroes all outputs (dut_busy, mac_en, mac_clr, dut_sram_write_enable, cfg_err, all addresses) and all counters.
REQ-036 An in-flight run is abandoned on reset with no further writes.

Structure
REQ-037 Package conv_seq_pkg holds the state enum, KERNEL_DIM=3, KERNEL_TAPS=9, N_MIN=3, N_MAX=63 and ADDR_WIDTH.
REQ-038 Window addressing lives in sub-module conv_addr_gen (tap, column and row counters plus incremental row-base registers), with no multiplier.
REQ-039 The mac_en, mac_clr and write strobes are derived from a 1-stage and 10-stage delayed tap-valid pipeline, not recomputed.

Verification
REQ-040 N=3 -> input addresses 1..9 and weight addresses 0..8 in cycles 3..11; one write to address 0 at cycle 13; busy high for 13 cycles.
REQ-041 N=4 -> P=4; pixel 1 first input address 2; pixel 2 first input address 5; writes to addresses 0..3 at cycles 13,22,31,40; busy for 40 cycles.
REQ-042 N=2 and N=0xFFFF -> cfg_err=1, zero writes, busy high for cycles 1-2 only; a following N=3 run clears cfg_err.
REQ-043 N=10 run with reset asserted at cycle 20 -> next cycle all outputs 0 with no writes; a subsequent run matches the clean N=10 trace.
REQ-044 dut_run held high throughout with N=3 -> second run accepted in the single idle cycle 14 after completion; busy low exactly that one cycle.
REQ-045 N=63 -> last input address 3969, last write address 3720 at cycle 33493, no address wrap.
